vend_fsm: RTL and testbench

//   Vending-machine control stage that feeds the price comparator and consumes its result.

---
 rtl/vend_fsm.sv | 115 +++++++++++
 tb/tb_vend_fsm.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_fsm.sv
// rtl/vend_fsm.sv - vending-machine control: coin credit, vend, change and refund payout
// Credit is kept in 5-cent units and compared externally against the price.
module vend_fsm #(
   parameter int SUM_W = 3,
   parameter int PRICE = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_nickel,
   input  logic             i_dime,
   input  logic             i_cancel,
   input  logic             i_sum_eq,
   input  logic             i_sum_lt,
   input  logic             i_soda_ack,
   input  logic             i_chg_ready,
   output logic [SUM_W-1:0] o_sum,
   output logic             o_accept,
   output logic             o_soda,
   output logic             o_chg_valid,
   output logic             o_busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_VEND,
      S_CHANGE,
      S_REFUND
   } state_t;

   localparam logic [SUM_W-1:0] PRICE_U = SUM_W'(PRICE);
   localparam logic [SUM_W-1:0] ONE_U   = SUM_W'(1);

   state_t           state_q, state_d;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic [SUM_W-1:0] coin_add;
   logic [SUM_W-1:0] sum_dec;

   assign coin_add = {{(SUM_W-1){1'b0}}, i_nickel} + {{(SUM_W-2){1'b0}}, i_dime, 1'b0};
   assign sum_dec  = sum_q - ONE_U;

   assign o_sum       = sum_q;
   assign o_accept    = ((state_q == S_IDLE) || (state_q == S_COLLECT)) && i_sum_lt && !i_rst;
   assign o_soda      = (state_q == S_VEND);
   assign o_chg_valid = (state_q == S_CHANGE) || (state_q == S_REFUND);
   assign o_busy      = (state_q != S_IDLE);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      case (state_q)
         S_IDLE: begin
            if (o_accept && (i_nickel || i_dime)) begin
               sum_d   = sum_q + coin_add;
               state_d = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (o_accept) begin
               sum_d = sum_q + coin_add;
            end
            // Cancel outranks a full credit so the buyer can still back out.
            if (i_cancel) begin
               state_d = S_REFUND;
            end else if (!i_sum_lt) begin
               state_d = S_VEND;
            end
         end
         S_VEND: begin
            if (i_soda_ack) begin
               if (i_sum_eq) begin
                  sum_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_CHANGE;
               end
            end
         end
         S_CHANGE: begin
            if (i_chg_ready) begin
               sum_d = sum_dec;
               if (sum_dec == PRICE_U) begin
                  sum_d   = '0;
                  state_d = S_IDLE;
               end
            end
         end
         S_REFUND: begin
            if (sum_q == '0) begin
               state_d = S_IDLE;
            end else if (i_chg_ready) begin
               sum_d = sum_dec;
               if (sum_q == ONE_U) begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            sum_d   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_vend_fsm.sv
// tb/tb_vend_fsm.sv - self-checking bench for vend_fsm
// A credit/payout reference model predicts every output after each clock.
module tb_vend_fsm;

   localparam int SUM_W = 3;
   localparam int PRICE = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             nickel = 1'b0, dime = 1'b0, cancel = 1'b0;
   logic             soda_ack = 1'b0, chg_ready = 1'b0;
   logic             sum_eq, sum_lt;
   logic [SUM_W-1:0] o_sum;
   logic             o_accept, o_soda, o_chg_valid, o_busy;
   logic [6:0]       dut_vec;

   int runs = 0;
   int fails = 0;

   // Reference model: credit in units, plus whether we are vending or paying nickels out.
   int m_credit = 0;
   bit m_vend = 0;
   bit m_ret = 0;
   bit m_refund = 0;

   always #5 clk = ~clk;

   assign sum_eq  = (o_sum == SUM_W'(PRICE));
   assign sum_lt  = (o_sum <  SUM_W'(PRICE));
   assign dut_vec = {o_sum, o_soda, o_chg_valid, o_busy, o_accept};

   vend_fsm #(.SUM_W(SUM_W), .PRICE(PRICE)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_nickel   (nickel),
      .i_dime     (dime),
      .i_cancel   (cancel),
      .i_sum_eq   (sum_eq),
      .i_sum_lt   (sum_lt),
      .i_soda_ack (soda_ack),
      .i_chg_ready(chg_ready),
      .o_sum      (o_sum),
      .o_accept   (o_accept),
      .o_soda     (o_soda),
      .o_chg_valid(o_chg_valid),
      .o_busy     (o_busy)
   );

   function automatic logic [6:0] exp_vec();
      logic acc;
      logic bsy;
      acc = !m_vend && !m_ret && (m_credit < PRICE) && !rst;
      bsy = m_vend || m_ret || (m_credit != 0);
      return {SUM_W'(m_credit), m_vend, m_ret, bsy, acc};
   endfunction

   task automatic set_in(input bit n, input bit d, input bit c, input bit a, input bit r);
      nickel = n; dime = d; cancel = c; soda_ack = a; chg_ready = r;
   endtask

   task automatic tick();
      int add;
      if (rst) begin
         m_credit = 0; m_vend = 0; m_ret = 0; m_refund = 0;
      end else if (m_vend) begin
         if (soda_ack) begin
            m_vend = 0;
            if (m_credit == PRICE) m_credit = 0;
            else begin m_ret = 1; m_refund = 0; end
         end
      end else if (m_ret) begin
         if (m_refund && m_credit == 0) m_ret = 0;
         else if (chg_ready) begin
            m_credit = m_credit - 1;
            if (m_refund && m_credit == 0) m_ret = 0;
            if (!m_refund && m_credit == PRICE) begin m_credit = 0; m_ret = 0; end
         end
      end else begin
         add = (m_credit < PRICE) ? (int'(nickel) + 2 * int'(dime)) : 0;
         if (cancel && m_credit > 0) begin
            m_credit = m_credit + add; m_ret = 1; m_refund = 1;
         end else if (m_credit >= PRICE) begin
            m_vend = 1;
         end else begin
            m_credit = m_credit + add;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_in(0, 0, 0, 0, 0);
      tick();
      tick();
      runs++;
      if (dut_vec !== exp_vec() || o_sum !== 3'd0 || o_busy !== 1'b0) begin
         fails++; $display("FAIL reset_state act=%b exp=%b", dut_vec, exp_vec());
      end
      rst = 1'b0;
      #1;
      runs++;
      if (o_accept !== 1'b1) begin
         fails++; $display("FAIL reset_accept act=%b exp=1", o_accept);
      end
   endtask

   task automatic test_exact_price();
      for (int i = 1; i <= 4; i++) begin
         set_in(1, 0, 0, 0, 0);
         tick();
         runs++;
         if (dut_vec !== exp_vec() || o_sum !== SUM_W'(i)) begin
            fails++; $display("FAIL t1_nickel%0d act=%b exp=%b", i, dut_vec, exp_vec());
         end
      end
      runs++;
      if (o_accept !== 1'b0) begin
         fails++; $display("FAIL t1_accept_closed act=%b exp=0", o_accept);
      end
      set_in(0, 0, 0, 0, 0);
      tick();
      runs++;
      if (o_soda !== 1'b1 || dut_vec !== exp_vec()) begin
         fails++; $display("FAIL t1_soda act=%b exp=%b", dut_vec, exp_vec());
      end
      set_in(0, 0, 0, 1, 0);
      tick();
      runs++;
      if (dut_vec !== exp_vec() || o_sum !== 3'd0 || o_busy !== 1'b0 || o_chg_valid !== 1'b0) begin
         fails++; $display("FAIL t1_ack_idle act=%b exp=%b", dut_vec, exp_vec());
      end
   endtask

   task automatic test_change();
      set_in(0, 1, 0, 0, 0); tick();
      set_in(1, 0, 0, 0, 0); tick();
      set_in(0, 1, 0, 0, 0); tick();
      runs++;
      if (o_sum !== 3'd5 || dut_vec !== exp_vec()) begin
         fails++; $display("FAIL t2_sum5 act=%b exp=%b", dut_vec, exp_vec());
      end
      set_in(0, 0, 0, 0, 0); tick();
      set_in(0, 0, 0, 1, 0); tick();
      runs++;
      if (o_chg_valid !== 1'b1 || o_soda !== 1'b0 || o_sum !== 3'd5 || dut_vec !== exp_vec()) begin
         fails++; $display("FAIL t2_change act=%b exp=%b", dut_vec, exp_vec());
      end
      set_in(0, 0, 0, 0, 1); tick();
      runs++;
      if (o_sum !== 3'd0 || o_busy !== 1'b0 || dut_vec !== exp_vec()) begin
         fails++; $display("FAIL t2_done act=%b exp=%b", dut_vec, exp_vec());
      end
      set_in(0, 0, 0, 0, 0);
   endtask

   task automatic test_both_coins();
      set_in(1, 1, 0, 0, 0); tick();
      runs++;
      if (o_sum !== 3'd3 || dut_vec !== exp_vec()) begin
         fails++; $display("FAIL t3_plus3 act=%b exp=%b", dut_vec, exp_vec());
      end
      set_in(0, 1, 0, 0, 0); tick();
      runs++;
      if (o_sum !== 3'd5 || dut_vec !== exp_vec()) begin
         fails++; $display("FAIL t3_sum5 act=%b exp=%b", dut_vec, exp_vec());
      end
      set_in(0, 0, 0, 0, 0); tick();
      set_in(1, 1, 0, 0, 0); tick();
      runs++;
      if (o_sum !== 3'd5 || o_soda !== 1'b1 || dut_vec !== exp_vec()) begin
         fails++; $display("FAIL t3_coin_in_vend act=%b exp=%b", dut_vec, exp_vec());
      end
      set_in(0, 0, 0, 1, 0); tick();
      set_in(0, 0, 0, 0, 1); tick();
      runs++;
      if (o_busy !== 1'b0 || dut_vec !== exp_vec()) begin
         fails++; $display("FAIL t3_done act=%b exp=%b", dut_vec, exp_vec());
      end
      set_in(0, 0, 0, 0, 0);
   endtask

   task automatic test_refund();
      set_in(1, 1, 0, 0, 0); tick();
      set_in(0, 0, 1, 0, 0); tick();
      set_in(0, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         tick();
         runs++;
         if (o_sum !== 3'd3 || o_chg_valid !== 1'b1 || dut_vec !== exp_vec()) begin
            fails++; $display("FAIL t4_hold%0d act=%b exp=%b", i, dut_vec, exp_vec());
         end
      end
      for (int i = 2; i >= 0; i--) begin
         set_in(0, 0, 0, 0, 1); tick();
         runs++;
         if (o_sum !== SUM_W'(i) || dut_vec !== exp_vec()) begin
            fails++; $display("FAIL t4_beat_to%0d act=%b exp=%b", i, dut_vec, exp_vec());
         end
      end
      runs++;
      if (o_busy !== 1'b0 || o_chg_valid !== 1'b0) begin
         fails++; $display("FAIL t4_idle busy=%b chg=%b exp=0,0", o_busy, o_chg_valid);
      end
      set_in(0, 0, 0, 0, 0);
   endtask

   task automatic test_cancel();
      set_in(0, 0, 1, 0, 0); tick();
      runs++;
      if (o_busy !== 1'b0 || o_chg_valid !== 1'b0 || dut_vec !== exp_vec()) begin
         fails++; $display("FAIL t5_idle_cancel act=%b exp=%b", dut_vec, exp_vec());
      end
      set_in(0, 1, 0, 0, 0); tick(); tick();
      set_in(0, 0, 0, 0, 0); tick();
      set_in(0, 0, 1, 0, 0); tick();
      runs++;
      if (o_soda !== 1'b1 || o_chg_valid !== 1'b0 || o_sum !== 3'd4 || dut_vec !== exp_vec()) begin
         fails++; $display("FAIL t5_vend_cancel act=%b exp=%b", dut_vec, exp_vec());
      end
      set_in(0, 0, 0, 1, 0); tick();
      set_in(1, 0, 0, 0, 0); tick();
      set_in(0, 1, 1, 0, 0); tick();
      runs++;
      if (o_sum !== 3'd3 || o_chg_valid !== 1'b1 || dut_vec !== exp_vec()) begin
         fails++; $display("FAIL t5_cancel_dime act=%b exp=%b", dut_vec, exp_vec());
      end
      set_in(0, 0, 0, 0, 1); tick(); tick(); tick();
      runs++;
      if (o_busy !== 1'b0 || dut_vec !== exp_vec()) begin
         fails++; $display("FAIL t5_drain act=%b exp=%b", dut_vec, exp_vec());
      end
      set_in(0, 0, 0, 0, 0);
   endtask

   task automatic test_reset_mid();
      for (int pass = 0; pass < 2; pass++) begin
         set_in(0, 1, 0, 0, 0); tick();
         set_in(1, 0, 0, 0, 0); tick();
         set_in(0, 1, 0, 0, 0); tick();
         set_in(0, 0, 0, 0, 0); tick();
         if (pass == 0) begin
            set_in(0, 0, 0, 1, 0); tick();
            set_in(0, 0, 0, 0, 0);
         end
         rst = 1'b1;
         tick();
         runs++;
         if (o_sum !== 3'd0 || o_soda !== 1'b0 || o_chg_valid !== 1'b0 || o_busy !== 1'b0
             || dut_vec !== exp_vec()) begin
            fails++; $display("FAIL t6_rst_pass%0d act=%b exp=%b", pass, dut_vec, exp_vec());
         end
         rst = 1'b0;
         #1;
         runs++;
         if (o_accept !== 1'b1) begin
            fails++; $display("FAIL t6_accept_pass%0d act=%b exp=1", pass, o_accept);
         end
      end
   endtask

   task automatic test_random();
      int bad = 0;
      for (int i = 0; i < 3000; i++) begin
         rst       = ($urandom_range(0, 63) == 0);
         nickel    = ($urandom_range(0, 2) == 0);
         dime      = ($urandom_range(0, 3) == 0);
         cancel    = ($urandom_range(0, 11) == 0);
         soda_ack  = ($urandom_range(0, 2) == 0);
         chg_ready = ($urandom_range(0, 1) == 0);
         tick();
         runs++;
         if (dut_vec !== exp_vec() || (o_soda && o_chg_valid)) begin
            fails++; bad++;
            if (bad <= 10) $display("FAIL rand_cycle%0d act=%b exp=%b", i, dut_vec, exp_vec());
         end
      end
      rst = 1'b0;
      set_in(0, 0, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_exact_price();
      test_change();
      test_both_coins();
      test_refund();
      test_cancel();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", runs, fails);
      $finish;
   end

endmodule
